// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter
// Shares the single read port (port B) of the character RAM between the
// tilemap pixel fetch (requester 0) and a secondary reader (requester 1).
// The RAM is synchronous, so read data returns one cycle after the address.
// A registered owner tag routes each returned word back to the requester
// that issued it. Each requester also has a hold register, so its data
// output stays stable between returns.
// Optional feature: define ARB_STARVE_GUARD_EN to build the starvation
// counter. Once requester 1 has been denied for STARVE_LIMIT consecutive
// cycles, it wins one contended cycle.

module char_ram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  valid0,
  output logic [DATA_WIDTH-1:0] data0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic                  valid1,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  own_vld;
  logic                  own_id;
  logic [DATA_WIDTH-1:0] hold0;
  logic [DATA_WIDTH-1:0] hold1;
  logic                  starve_win;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve;

  assign starve_win = (starve >= 4'(STARVE_LIMIT));

  // Count consecutive denied cycles of requester 1, saturating at 15
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= 4'd0;
    end else if (!req1 || gnt1) begin
      starve <= 4'd0;
    end else if (starve != 4'hF) begin
      starve <= starve + 4'd1;
    end
  end
`else
  logic starve_limit_unused;

  assign starve_win          = 1'b0;
  assign starve_limit_unused = (STARVE_LIMIT > 0);
`endif

  // Pick at most one requester: requester 0 has priority unless requester 1 is starving
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req1 && (!req0 || starve_win)) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  // Drive the granted address, or keep the last one when nobody is granted
  always_comb begin
    ram_addr = ram_addr_q;
    if (gnt0) begin
      ram_addr = addr0;
    end else if (gnt1) begin
      ram_addr = addr1;
    end
  end

  // Remember the driven address so idle cycles keep it stable
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q <= '0;
    end else begin
      ram_addr_q <= ram_addr;
    end
  end

  // Owner tag for the word the RAM returns next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      own_vld <= 1'b0;
      own_id  <= 1'b0;
    end else begin
      own_vld <= gnt0 | gnt1;
      own_id  <= gnt1;
    end
  end

  // A return still in flight while reset is high is dropped
  assign valid0 = own_vld && !own_id && !rst;
  assign valid1 = own_vld &&  own_id && !rst;

  // Capture each returned word so the data outputs hold between returns
  always_ff @(posedge clk) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (valid0) begin
        hold0 <= ram_q;
      end
      if (valid1) begin
        hold1 <= ram_q;
      end
    end
  end

  assign data0 = valid0 ? ram_q : hold0;
  assign data1 = valid1 ? ram_q : hold1;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// tb_char_ram_arbiter
// Directed bench for char_ram_arbiter with a behavioural synchronous RAM.
// The table rows are one clock cycle each. A row gives the inputs and the
// outputs expected in that same cycle. Hand-written sequences cover
// contention and reset in mid-flight. Contention expectations follow
// ARB_STARVE_GUARD_EN.

module tb_char_ram_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        req0;
    logic [7:0]  addr0;
    logic        req1;
    logic [7:0]  addr1;
    logic        e_gnt0;
    logic        e_gnt1;
    logic        e_valid0;
    logic        e_valid1;
    logic [15:0] e_data0;
    logic [15:0] e_data1;
    logic [7:0]  e_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0;
  logic [7:0]  addr0;
  logic        gnt0;
  logic        valid0;
  logic [15:0] data0;
  logic        req1;
  logic [7:0]  addr1;
  logic        gnt1;
  logic        valid1;
  logic [15:0] data1;
  logic [7:0]  ram_addr;
  logic [15:0] ram_q = 16'h0000;

  logic [15:0] mem [256];

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [19];

  char_ram_arbiter #(
    .ADDR_WIDTH   (8),
    .DATA_WIDTH   (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .addr0    (addr0),
    .gnt0     (gnt0),
    .valid0   (valid0),
    .data0    (data0),
    .req1     (req1),
    .addr1    (addr1),
    .gnt1     (gnt1),
    .valid1   (valid1),
    .data1    (data1),
    .ram_addr (ram_addr),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: the word for an address appears one cycle later
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
  end

  function automatic logic [15:0] expData(input logic [7:0] a);
    return (a == 8'h12) ? 16'hBEEF : (16'hA500 | {8'h00, a});
  endfunction

  function automatic vec_t mk(input logic r, input logic q0, input logic [7:0] a0,
                              input logic q1, input logic [7:0] a1,
                              input logic g0, input logic g1, input logic v0, input logic v1,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [7:0] ea);
    vec_t v;
    v.rst = r; v.req0 = q0; v.addr0 = a0; v.req1 = q1; v.addr1 = a1;
    v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_valid0 = v0; v.e_valid1 = v1;
    v.e_data0 = d0; v.e_data1 = d1; v.e_addr = ea;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic q0, input logic [7:0] a0,
                               input logic q1, input logic [7:0] a1);
    @(negedge clk);
    rst   = r;
    req0  = q0;
    addr0 = a0;
    req1  = q1;
    addr1 = a1;
    #1;
  endtask

  task automatic checkRow(input string tag, input vec_t v);
    checkOutput({tag, " gnt0"},     {15'd0, gnt0},   {15'd0, v.e_gnt0});
    checkOutput({tag, " gnt1"},     {15'd0, gnt1},   {15'd0, v.e_gnt1});
    checkOutput({tag, " valid0"},   {15'd0, valid0}, {15'd0, v.e_valid0});
    checkOutput({tag, " valid1"},   {15'd0, valid1}, {15'd0, v.e_valid1});
    checkOutput({tag, " data0"},    data0,           v.e_data0);
    checkOutput({tag, " data1"},    data1,           v.e_data1);
    checkOutput({tag, " ram_addr"}, {8'd0, ram_addr}, {8'd0, v.e_addr});
  endtask

  initial begin
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] prev_addr;
    logic       prev_vld;
    logic       prev_id;
    logic       exp1;

    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
    mem[8'h12] = 16'hBEEF;

    rst = 1'b1; req0 = 1'b0; addr0 = 8'h00; req1 = 1'b0; addr1 = 8'h00;

    //             rst  q0  a0     q1  a1     g0  g1  v0  v1  d0        d1        addr
    vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[2]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[3]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[4]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);
    vecs[5]  = mk(0, 1, 8'h12, 0, 8'h00, 1, 0, 0, 0, 16'h0000, 16'h0000, 8'h12);
    vecs[6]  = mk(0, 0, 8'h12, 0, 8'h00, 0, 0, 1, 0, 16'hBEEF, 16'h0000, 8'h12);
    vecs[7]  = mk(0, 0, 8'h12, 0, 8'h00, 0, 0, 0, 0, 16'hBEEF, 16'h0000, 8'h12);
    vecs[8]  = mk(0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 16'hBEEF, 16'h0000, 8'h00);
    vecs[9]  = mk(0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 1, 16'hBEEF, 16'hA500, 8'h01);
    vecs[10] = mk(0, 0, 8'h00, 1, 8'h02, 0, 1, 0, 1, 16'hBEEF, 16'hA501, 8'h02);
    vecs[11] = mk(0, 0, 8'h00, 1, 8'h03, 0, 1, 0, 1, 16'hBEEF, 16'hA502, 8'h03);
    vecs[12] = mk(0, 0, 8'h00, 0, 8'h03, 0, 0, 0, 1, 16'hBEEF, 16'hA503, 8'h03);
    vecs[13] = mk(0, 0, 8'h00, 0, 8'h03, 0, 0, 0, 0, 16'hBEEF, 16'hA503, 8'h03);
    vecs[14] = mk(0, 1, 8'h40, 1, 8'h41, 1, 0, 0, 0, 16'hBEEF, 16'hA503, 8'h40);
    vecs[15] = mk(0, 0, 8'h40, 1, 8'h41, 0, 1, 1, 0, 16'hA540, 16'hA503, 8'h41);
    vecs[16] = mk(0, 1, 8'h42, 0, 8'h41, 1, 0, 0, 1, 16'hA540, 16'hA541, 8'h42);
    vecs[17] = mk(0, 0, 8'h42, 0, 8'h41, 0, 0, 1, 0, 16'hA542, 16'hA541, 8'h42);
    vecs[18] = mk(0, 0, 8'h42, 0, 8'h41, 0, 0, 0, 0, 16'hA542, 16'hA541, 8'h42);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req0, vecs[i].addr0, vecs[i].req1, vecs[i].addr1);
      checkRow($sformatf("row%0d", i), vecs[i]);
    end

    // Contention: both requesters held for 10 cycles
    a0 = 8'h50; a1 = 8'h60; prev_vld = 1'b0; prev_id = 1'b0; prev_addr = 8'h00;
    for (int k = 0; k < 10; k++) begin
      exp1 = GUARD && (k == 4 || k == 9);
      applyStimulus(1'b0, 1'b1, a0, 1'b1, a1);
      checkOutput($sformatf("cont%0d gnt0", k), {15'd0, gnt0}, {15'd0, !exp1});
      checkOutput($sformatf("cont%0d gnt1", k), {15'd0, gnt1}, {15'd0, exp1});
      checkOutput($sformatf("cont%0d ram_addr", k), {8'd0, ram_addr}, {8'd0, exp1 ? a1 : a0});
      checkOutput($sformatf("cont%0d valid0", k), {15'd0, valid0}, {15'd0, prev_vld && !prev_id});
      checkOutput($sformatf("cont%0d valid1", k), {15'd0, valid1}, {15'd0, prev_vld && prev_id});
      if (prev_vld && !prev_id) checkOutput($sformatf("cont%0d data0", k), data0, expData(prev_addr));
      if (prev_vld &&  prev_id) checkOutput($sformatf("cont%0d data1", k), data1, expData(prev_addr));
      prev_vld  = 1'b1;
      prev_id   = exp1;
      prev_addr = exp1 ? a1 : a0;
      if (exp1) a1 = a1 + 8'd1;
      else      a0 = a0 + 8'd1;
    end
    applyStimulus(1'b0, 1'b0, a0, 1'b0, a1);
    checkOutput("cont_tail gnt0",   {15'd0, gnt0},   16'd0);
    checkOutput("cont_tail gnt1",   {15'd0, gnt1},   16'd0);
    checkOutput("cont_tail valid0", {15'd0, valid0}, {15'd0, !prev_id});
    checkOutput("cont_tail valid1", {15'd0, valid1}, {15'd0, prev_id});
    checkOutput("cont_tail data",   prev_id ? data1 : data0, expData(prev_addr));

    // Reset mid-flight: grant requester 0, then reset before its data returns
    applyStimulus(1'b0, 1'b1, 8'h20, 1'b0, 8'h03);
    checkOutput("rmf grant gnt0",     {15'd0, gnt0}, 16'd1);
    checkOutput("rmf grant ram_addr", {8'd0, ram_addr}, 16'h0020);
    applyStimulus(1'b1, 1'b0, 8'h20, 1'b1, 8'h03);
    checkOutput("rmf rst valid0", {15'd0, valid0}, 16'd0);
    checkOutput("rmf rst gnt0",   {15'd0, gnt0},   16'd0);
    checkOutput("rmf rst gnt1",   {15'd0, gnt1},   16'd0);
    applyStimulus(1'b0, 1'b0, 8'h20, 1'b1, 8'h03);
    checkOutput("rmf rel valid0",   {15'd0, valid0}, 16'd0);
    checkOutput("rmf rel data0",    data0, 16'h0000);
    checkOutput("rmf rel data1",    data1, 16'h0000);
    checkOutput("rmf rel gnt1",     {15'd0, gnt1}, 16'd1);
    checkOutput("rmf rel ram_addr", {8'd0, ram_addr}, 16'h0003);
    applyStimulus(1'b0, 1'b0, 8'h20, 1'b0, 8'h03);
    checkOutput("rmf ret valid0", {15'd0, valid0}, 16'd0);
    checkOutput("rmf ret valid1", {15'd0, valid1}, 16'd1);
    checkOutput("rmf ret data1",  data1, 16'hA503);
    checkOutput("rmf ret data0",  data0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 8'h20, 1'b0, 8'h03);
    checkOutput("rmf idle valid1", {15'd0, valid1}, 16'd0);
    checkOutput("rmf idle data1",  data1, 16'hA503);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_ram_arbiter.md
# char_ram_arbiter

Shares the single read port (port B) of the GPU's character RAM between two requesters. Requester 0 is the tilemap layer processor's pixel fetch; requester 1 is a secondary reader such as a scroll or tile-attribute engine. The block sits between those requesters and the dual-port RAM's read address and data lines. It grants at most one read per cycle, routes each returned word back to its owner, and holds the last word per requester.

## Interface
Parameters:
- ADDR_WIDTH, 8, char RAM port B address width
- DATA_WIDTH, 16, char RAM port B data width
- STARVE_LIMIT, 4, consecutive denied cycles after which requester 1 wins (range 1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 read request
- addr0  input  ADDR_WIDTH  requester 0 address
- gnt0  output  1  requester 0 granted this cycle (combinational)
- valid0  output  1  requester 0 data returned this cycle
- data0  output  DATA_WIDTH  requester 0 read data
- req1, addr1, gnt1, valid1, data1: same as above for requester 1
- ram_addr  output  ADDR_WIDTH  to RAM port B address
- ram_q  input  DATA_WIDTH  from RAM port B; synchronous RAM, valid one cycle after address

## Operation
- Handshake: a requester raises reqN with addrN and holds both stable until it sees gntN high. A read completes on any cycle with reqN && gntN. Back-to-back reads are legal: keep reqN high and change addrN after each grant.
- Arbitration (combinational, every cycle):
  - Only one requester: that requester is granted.
  - Both requesting: requester 0 wins, unless the starvation rule (see Configuration) selects requester 1.
  - No request: no grant, and ram_addr holds its last driven value.
- ram_addr = address of the granted requester; otherwise the previous ram_addr (registered hold).
- Return pipeline:
  - Registered one-deep owner tag: own_vld and own_id, loaded every cycle from the grant.
  - validN = own_vld && own_id==N.
- Data:
  - dataN = ram_q while validN is high.
  - Otherwise dataN = holdN, a register updated with ram_q on every validN cycle.
  - dataN is therefore stable between returns.
- Starvation counter: 4-bit starve.
  - Increments when req1 is high and gnt1 is low.
  - Clears when gnt1 is high or req1 is low.
  - Saturates at 15.
- Reset mid-operation: the in-flight return is discarded and no valid pulse follows reset.

## Timing
- Grant latency: 0 cycles (gntN is in the same cycle as reqN, when that requester wins).
- Read latency: validN and dataN appear exactly 1 cycle after the granting cycle.
- Throughput: one read per cycle aggregate, no bubbles between consecutive grants, including grants that switch owner.
- Reset values:
  - gnt0 = gnt1 = 0 while rst is high.
  - valid0 = valid1 = 0.
  - data0 = data1 = 0 (hold registers cleared).
  - ram_addr = 0.
  - starve = 0, own_vld = 0.
- A grant in the cycle rst deasserts is legal; its valid appears on the next cycle.
- Simultaneous events: both requesters can never be granted in one cycle. On an owner switch, the returning valid belongs to the previous cycle's owner, and the new grant's valid follows one cycle later.

## Configuration
ARB_STARVE_GUARD_EN:
- Defined: when both requesters are active and starve >= STARVE_LIMIT, requester 1 is granted instead of requester 0. starve then clears. Requester 0 is delayed by at most 1 cycle per STARVE_LIMIT+1 cycles.
- Undefined: strict fixed priority. The starve counter is not built, and requester 1 can starve indefinitely while req0 is held high.

## Test plan
- Reset, then idle: hold rst 3 cycles, then release with no requests. gnt0, gnt1, valid0 and valid1 all stay 0, and data0 = data1 = 0.
- Single read: RAM[0x12]=0xBEEF; pulse req0 with addr0=0x12. gnt0=1 in the same cycle, valid0=1 next cycle with data0=0xBEEF, and data0 stays 0xBEEF afterwards.
- Burst: req1 held for 4 cycles with addr1=0x00..0x03. Four consecutive gnt1 pulses, then valid1 on 4 consecutive cycles returning RAM[0..3] in order.
- Contention without guard: req0 and req1 both held for 10 cycles, macro undefined. gnt0=1 every cycle and gnt1 never asserts.
- Contention with guard: same stimulus, ARB_STARVE_GUARD_EN defined, STARVE_LIMIT=4. gnt1 pulses on cycles 5 and 10; requester 0 gets the other 8 grants, and each valid routes to the correct owner.
- Reset mid-flight: grant req0 at addr 0x20 and assert rst in the next cycle. valid0 stays 0 and data0 reads 0 after reset.
